// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_pkg
//  Description : Shared types and constants for the Trivium keystream
//                consumer (FSM state encoding, warm-up length, counter width).
//  Revision    : 1.0  initial release
// ============================================================================
package trivium_pkg;

  // Keystream consumer states
  typedef enum logic [1:0] {
    WARMUP = 2'd0,   // generator advancing, output discarded
    FILL   = 2'd1,   // generator advancing, bits collected into a byte
    HOLD   = 2'd2    // generator frozen, full keystream byte waiting
  } ks_state_e;

  // Four full passes over the 288-bit internal state before output is used
  localparam int TRIVIUM_STATE_BITS = 288;
  localparam int TRIVIUM_WARMUP     = 4 * TRIVIUM_STATE_BITS;

  // Warm-up counter width; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_ks_byte.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_ks_byte
//  Description : Bit-to-byte keystream collector. The first captured bit
//                lands in bit 0; done pulses on the cycle the last bit of a
//                byte is shifted in.
//  Revision    : 1.0  initial release
// ============================================================================
module trivium_ks_byte #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_in,
  output logic [DATA_W-1:0] byte_out,
  output logic              done
);

  localparam int              IDX_W    = (DATA_W <= 2) ? 1 : $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;

  assign done     = shift_en && (idx == LAST_IDX);
  assign byte_out = shreg;

  // Bit index: restarts on clear, wraps after the last bit of a byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (shift_en) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // Right shift with new bit entering the MSB, so after DATA_W shifts the
  // first captured bit sits in the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {bit_in, shreg[DATA_W-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/trivium_stream_xor.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_stream_xor
//  Description : Receive-side keystream consumer. Discards the generator
//                warm-up output, packs keystream bits into bytes, XORs each
//                byte with one accepted ciphertext byte and presents the
//                plaintext on a registered valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module trivium_stream_xor
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = TRIVIUM_WARMUP,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ks_bit,
  output logic              ks_en,
  input  logic [DATA_W-1:0] ct_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  output logic [DATA_W-1:0] pt_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              ks_locked
);

  localparam int               CNT_W    = cnt_width(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

  ks_state_e         state;
  ks_state_e         state_nxt;
  logic [CNT_W-1:0]  warm_cnt;
  logic [DATA_W-1:0] ks_byte;
  logic              ks_done;
  logic              fill_shift;
  logic              ct_fire;
  logic              ks_clear;
  logic              locked_q;

  assign ks_clear  = start || ct_fire;
  assign ks_locked = locked_q;

  trivium_ks_byte #(
    .DATA_W (DATA_W)
  ) u_ks_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (fill_shift),
    .clear    (ks_clear),
    .bit_in   (ks_bit),
    .byte_out (ks_byte),
    .done     (ks_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WARMUP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, generator enable and ciphertext handshake; start overrides all
  always_comb begin
    state_nxt  = state;
    ks_en      = 1'b1;
    ct_ready   = 1'b0;
    ct_fire    = 1'b0;
    fill_shift = 1'b0;
    case (state)
      WARMUP: begin
        if (warm_cnt == CNT_LAST) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        fill_shift = !start;
        if (ks_done) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        ks_en    = 1'b0;
        ct_ready = (!pt_valid || pt_ready) && !start;
        ct_fire  = ct_valid && ct_ready;
        if (ct_fire) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = WARMUP;
      end
    endcase
    if (start) begin
      state_nxt = WARMUP;
    end
  end

  // Warm-up counter: runs only in WARMUP, parked at zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (start || (state != WARMUP) || (warm_cnt == CNT_LAST)) begin
      warm_cnt <= '0;
    end else begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Lock flag tracks the registered state leaving WARMUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= (state_nxt != WARMUP);
    end
  end

  // Plaintext output register: load wins over drain, start flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_valid <= 1'b0;
      pt_data  <= '0;
    end else if (start) begin
      pt_valid <= 1'b0;
    end else if (ct_fire) begin
      pt_valid <= 1'b1;
      pt_data  <= ct_data ^ ks_byte;
    end else if (pt_ready) begin
      pt_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trivium_stream_xor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trivium_stream_xor
//  Description : Self-checking bench for trivium_stream_xor. Unit 0 uses the
//                full 1152-cycle warm-up, unit 1 a 4-cycle warm-up for
//                streaming. A generator stand-in feeds a fixed keystream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trivium_stream_xor;

  logic       clk;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] ks_bit;
  logic [1:0] ks_en;
  logic [1:0] ct_valid;
  logic [1:0] ct_ready;
  logic [1:0] pt_valid;
  logic [1:0] pt_ready;
  logic [1:0] ks_locked;
  logic [7:0] ct_data [2];
  logic [7:0] pt_data [2];

  int checks = 0;
  int errors = 0;

  // Generator stand-in positions and abstract model state per unit
  int         gen_pos [2];
  int         m_pos   [2];
  int         m_cons  [2];
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  int         drained1 = 0;

  function automatic int warm(input int u);
    return (u == 0) ? 1152 : 4;
  endfunction

  // Keystream bit at generator position pos; first post-warm-up byte is 0xA5
  function automatic logic ks_fn(input int pos, input int w);
    logic [7:0]  pat;
    logic [31:0] x;
    pat = 8'hA5;
    if (pos >= w && pos < w + 8) return pat[pos - w];
    x = pos * 32'h9E3779B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EBCA6B;
    x = x ^ (x >> 13);
    return x[7];
  endfunction

  // k-th usable keystream byte after warm-up, bit i = i-th bit in time
  function automatic logic [7:0] key_byte(input int k, input int w);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ks_fn(w + 8 * k + i, w);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  trivium_stream_xor #(.WARMUP_CYCLES(1152), .DATA_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .ks_bit(ks_bit[0]), .ks_en(ks_en[0]),
    .ct_data(ct_data[0]), .ct_valid(ct_valid[0]), .ct_ready(ct_ready[0]),
    .pt_data(pt_data[0]), .pt_valid(pt_valid[0]), .pt_ready(pt_ready[0]),
    .ks_locked(ks_locked[0])
  );

  trivium_stream_xor #(.WARMUP_CYCLES(4), .DATA_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .ks_bit(ks_bit[1]), .ks_en(ks_en[1]),
    .ct_data(ct_data[1]), .ct_valid(ct_valid[1]), .ct_ready(ct_ready[1]),
    .pt_data(pt_data[1]), .pt_valid(pt_valid[1]), .pt_ready(pt_ready[1]),
    .ks_locked(ks_locked[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ks_bit[0] = ks_fn(gen_pos[0], 1152);
  assign ks_bit[1] = ks_fn(gen_pos[1], 4);

  // Generator stand-in: held in reset, reloaded on start, advances on ks_en
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n || start[u]) gen_pos[u] <= 0;
      else if (ks_en[u])      gen_pos[u] <= gen_pos[u] + 1;
    end
  end

  // Abstract model: a keystream byte is pending once the generator has run
  // past warm-up plus eight bits per byte already consumed
  task automatic model_step(input int u);
    int   w;
    logic e_ks, e_rdy, e_lock;
    w      = warm(u);
    e_ks   = (m_pos[u] < w + 8 * (m_cons[u] + 1));
    e_rdy  = !e_ks && (!m_valid[u] || pt_ready[u]) && !start[u];
    e_lock = (m_pos[u] >= w);
    chk($sformatf("u%0d ks_en", u), ks_en[u], e_ks);
    chk($sformatf("u%0d ct_ready", u), ct_ready[u], e_rdy);
    chk($sformatf("u%0d ks_locked", u), ks_locked[u], e_lock);
    chk($sformatf("u%0d pt_valid", u), pt_valid[u], m_valid[u]);
    if (m_valid[u]) chk($sformatf("u%0d pt_data", u), pt_data[u], m_data[u]);
    if (u == 1 && pt_valid[1] && pt_ready[1] && !start[1]) drained1++;
    if (start[u]) begin
      m_pos[u]   = 0;
      m_cons[u]  = 0;
      m_valid[u] = 1'b0;
    end else begin
      if (ct_valid[u] && e_rdy) begin
        m_data[u]  = ct_data[u] ^ key_byte(m_cons[u], w);
        m_valid[u] = 1'b1;
        m_cons[u]  = m_cons[u] + 1;
      end else if (pt_ready[u]) begin
        m_valid[u] = 1'b0;
      end
      if (e_ks) m_pos[u] = m_pos[u] + 1;
    end
  endtask

  // Compare process, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int u = 0; u < 2; u++) begin
          m_pos[u]   = 0;
          m_cons[u]  = 0;
          m_valid[u] = 1'b0;
          m_data[u]  = 8'h00;
        end
      end else begin
        for (int u = 0; u < 2; u++) model_step(u);
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;
    int sent;
    int cyc;
    logic found;

    rst_n       = 1'b0;
    start       = 2'b00;
    ct_valid    = 2'b00;
    pt_ready    = 2'b10;
    ct_data[0]  = 8'h3C;
    ct_data[1]  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst ct_ready", ct_ready[0], 1'b0);
    chk("rst pt_valid", pt_valid[0], 1'b0);
    chk("rst pt_data", pt_data[0], 8'h00);
    chk("rst ks_locked", ks_locked[0], 1'b0);
    chk("rst ks_en", ks_en[0], 1'b1);

    // Release; ciphertext 0x3C offered continuously, output stalled
    @(posedge clk); #1;
    rst_n       = 1'b1;
    ct_valid[0] = 1'b1;
    found = 1'b0;
    n     = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      if (ct_ready[0]) found = 1'b1;
      else n++;
    end
    chk("first ct_ready cycle", n, 1160);
    chk("ks_en low in HOLD", ks_en[0], 1'b0);
    chk("ks_locked at HOLD", ks_locked[0], 1'b1);

    // Handshake at this edge; offer a second byte afterwards
    @(posedge clk); #1;
    ct_data[0] = 8'h5A;
    @(negedge clk);
    chk("xor pt_valid", pt_valid[0], 1'b1);
    chk("xor pt_data 0xA5^0x3C", pt_data[0], 8'h99);

    // Backpressure: second keystream byte prefetched, then frozen in HOLD
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("stalled pt_data", pt_data[0], 8'h99);
    end
    chk("stalled ks_en", ks_en[0], 1'b0);
    chk("stalled ct_ready", ct_ready[0], 1'b0);

    @(posedge clk); #1;
    pt_ready[0] = 1'b1;
    @(negedge clk);
    chk("drain+load ct_ready", ct_ready[0], 1'b1);
    @(posedge clk); #1;
    ct_valid[0] = 1'b0;
    @(negedge clk);
    chk("drain+load pt_valid", pt_valid[0], 1'b1);
    @(posedge clk); #1;
    pt_ready[0] = 1'b0;

    // Mid-operation restart: get a fresh plaintext held, then start in FILL
    found = 1'b0;
    n     = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (ct_ready[0]) found = 1'b1;
      else n++;
    end
    chk("restart setup ct_ready", found, 1'b1);
    @(posedge clk); #1;
    ct_valid[0] = 1'b1;
    ct_data[0]  = 8'h11;
    @(posedge clk); #1;
    ct_valid[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    start[0] = 1'b1;
    @(negedge clk);
    chk("pre-start pt_valid", pt_valid[0], 1'b1);
    @(posedge clk); #1;
    start[0] = 1'b0;
    found = 1'b0;
    n     = 1;
    @(negedge clk);
    chk("post-start pt_valid", pt_valid[0], 1'b0);
    chk("post-start ks_locked", ks_locked[0], 1'b0);
    while (!found && n < 2000) begin
      if (ct_ready[0]) found = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    chk("restart ct_ready distance", n, 1161);

    // start colliding with a ciphertext handshake in HOLD
    @(posedge clk); #1;
    start[0]    = 1'b1;
    ct_valid[0] = 1'b1;
    ct_data[0]  = 8'h77;
    @(negedge clk);
    chk("collide ct_ready", ct_ready[0], 1'b0);
    @(posedge clk); #1;
    start[0]    = 1'b0;
    ct_valid[0] = 1'b0;
    @(negedge clk);
    chk("collide pt_valid", pt_valid[0], 1'b0);

    // Short warm-up unit: restart, then stream 16 random bytes
    @(posedge clk); #1;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1]    = 1'b0;
    ct_valid[1] = 1'b1;
    ct_data[1]  = 8'($urandom);
    sent = 0;
    cyc  = 0;
    while (sent < 16 && cyc < 3000) begin
      @(negedge clk);
      if (ct_ready[1]) sent++;
      @(posedge clk); #1;
      cyc++;
      ct_data[1]  = 8'($urandom);
      pt_ready[1] = 1'($urandom_range(0, 1));
      if (sent == 16) ct_valid[1] = 1'b0;
    end
    chk("stream bytes accepted", sent, 16);
    pt_ready[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("stream bytes delivered", drained1, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trivium_stream_xor.md
# trivium_stream_xor

Receive-side keystream consumer for the Trivium ASIC. The block drives the keystream generator's advance enable and discards the 1152-cycle initialisation output. It then packs keystream bits into bytes and XORs each byte with one ciphertext byte accepted over a valid/ready port. The resulting plaintext byte is presented on a registered valid/ready output. It sits between the `trivium` core and the pin-level byte interface of the top wrapper.

## Interface

Parameters:
- `WARMUP_CYCLES`, 1152: generator cycles discarded after reset or `start` (4×288).
- `DATA_W`, 8: byte width; the block is only verified at 8.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; the generator is reloaded upstream in the same cycle and this block restarts warm-up.
- `ks_bit`  in  1  keystream bit from the generator, meaningful in every cycle where `ks_en`=1.
- `ks_en`  out  1  generator advance enable.
- `ct_data`  in  DATA_W  ciphertext byte.
- `ct_valid`  in  1  ciphertext valid.
- `ct_ready`  out  1  ciphertext accept.
- `pt_data`  out  DATA_W  plaintext byte (registered).
- `pt_valid`  out  1  plaintext valid (registered).
- `pt_ready`  in  1  plaintext accept.
- `ks_locked`  out  1  high once warm-up is complete (any state except WARMUP).

## Operation

- **States:**
  - WARMUP: `ks_en`=1, bits discarded, counter counts.
  - FILL: `ks_en`=1, bits shifted in.
  - HOLD: `ks_en`=0, full keystream byte waiting.
- **WARMUP → FILL:** when the counter reaches `WARMUP_CYCLES`-1 (that cycle still advances the generator).
- **FILL:**
  - The first captured bit goes to the LSB; byte bit i = i-th captured bit.
  - A 3-bit index counts captured bits.
  - FILL → HOLD after the 8th bit.
- **HOLD:**
  - `ct_ready` = (state==HOLD) && (!`pt_valid` || `pt_ready`).
  - On a `ct_valid`&&`ct_ready` handshake: `pt_data` ← `ct_data` ^ ks_byte, `pt_valid` ← 1, state → FILL, and the index clears.
- **Output register:**
  - `pt_valid` clears on `pt_valid`&&`pt_ready`, unless a new load occurs in the same cycle.
  - A simultaneous drain and load keeps `pt_valid`=1 with the new data.
  - `pt_data` is held stable while `pt_valid`=1 and `pt_ready`=0.
- **Keystream prefetch:** the next keystream byte is collected while the output is stalled. In HOLD the generator is frozen, so no keystream bit is ever lost or skipped.
- **`start`:** highest priority in any state. Next cycle:
  - state = WARMUP, counter = 0, index = 0, `pt_valid` = 0.
  - A ciphertext handshake in the same cycle as `start` is ignored (`ct_ready` is forced to 0 while `start`=1).
- **Ignored inputs:** `ct_data` and `ks_bit` are ignored when not consumed.

## Timing

- **During reset (`rst_n`=0):**
  - state = WARMUP, counter = 0, `ks_en`=1 (the generator is itself held in reset).
  - `ct_ready`=0, `pt_valid`=0, `pt_data`=0, `ks_locked`=0.
- **From the first rising edge after `rst_n` deasserts (cycle 0):**
  - Cycles 0…1151: WARMUP.
  - Cycles 1152…1159: FILL.
  - Cycle 1160: HOLD, `ct_ready`=1, `ks_locked`=1.
- **Pipeline timing:**
  - Latency from ciphertext handshake to `pt_valid` is 1 cycle.
  - Sustained throughput is 1 byte per 9 cycles (8 FILL + 1 HOLD) when `ct_valid`=1 and `pt_ready`=1.
- **After `start` at cycle s:** the first `ct_ready` is at s+1+1160.
- `ks_en` and `ct_ready` are combinational from state and `pt_valid`/`pt_ready`/`start`. All other outputs are registered.

## Structure

- **Package `trivium_pkg`:**
  - state enum (WARMUP, FILL, HOLD).
  - `TRIVIUM_WARMUP` = 1152.
  - `TRIVIUM_STATE_BITS` = 288.
  - Counter width = $clog2(`WARMUP_CYCLES`).
- **Sub-module `trivium_ks_byte`:**
  - Bit-to-byte collector: shift register, 3-bit index, `done` pulse.
  - Controlled by a `shift_en` and `clear` input.
- **Top level:** FSM, warm-up counter, XOR, and output register stay in `trivium_stream_xor`.

## Test plan

- **Reset timing:** reset, then `ct_valid`=1 constantly → `ct_ready` first high exactly at cycle 1160, and `ks_en` falls the same cycle.
- **XOR and bit order:** drive `ks_bit` so the first captured byte is bits 1,0,1,0,0,1,0,1 (LSB first = 0xA5), with `ct_data`=0x3C → `pt_data`=0x99 and `pt_valid` high one cycle after the handshake.
- **Backpressure:** `pt_ready`=0 with two ciphertext bytes offered → first accepted, second stalls. The second keystream byte is collected and `ks_en`=0 in HOLD. `pt_data` is stable; raising `pt_ready` accepts the second byte in the same cycle.
- **Mid-operation restart:** pulse `start` during FILL at index 5 with `pt_valid`=1 → `pt_valid`=0 next cycle, and the next `ct_ready` arrives 1161 cycles after `start`.
- **`start` collides with handshake:** `start` asserted in the same cycle as `ct_valid` in HOLD → no plaintext is produced and `ct_ready`=0 that cycle.
- **Short warm-up and streaming:** `WARMUP_CYCLES`=4, bench reference-model keystream, 16 random bytes with random `pt_ready` → all 16 plaintexts match the model, with no byte dropped or duplicated.
